// File: rtl/conv_window_ctrl.sv
// Convolution window sequencer: slides a KxK window over an SRAM image and accumulates pixel*weight sums.
// Optional build macro CONV_WINDOW_SAT_EN clamps each reported window sum to the pixel range.
`timescale 1ns/1ps
module conv_window_ctrl #(
  parameter int KERNEL_SIZE     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int IMG_WIDTH       = 8,
  parameter int IMG_HEIGHT      = 8,
  parameter int SRAM_ADDR_WIDTH = 6,
  parameter int ACC_WIDTH       = 20,
  localparam int KIDX_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE * KERNEL_SIZE) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_sram_en,
  output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [DATA_WIDTH-1:0]      i_sram_data,
  output logic [KIDX_W-1:0]          o_kernel_idx,
  input  logic [DATA_WIDTH-1:0]      i_kernel_data,
  output logic [ACC_WIDTH-1:0]       o_result,
  output logic                       o_result_valid,
  input  logic                       i_result_ready,
  output logic                       o_done
);

  localparam int OUT_W = IMG_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H = IMG_HEIGHT - KERNEL_SIZE + 1;
  localparam int KC_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int RC_W  = $clog2(((OUT_W > OUT_H) ? OUT_W : OUT_H) + 1);

  localparam logic [KC_W-1:0] K_LAST   = KC_W'(KERNEL_SIZE - 1);
  localparam logic [RC_W-1:0] COL_LAST = RC_W'(OUT_W - 1);
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(OUT_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUTPUT, S_DONE} state_t;

  state_t                     state_q;
  logic [RC_W-1:0]            row_q, col_q;
  logic [KC_W-1:0]            kr_q, kc_q;
  logic [KIDX_W-1:0]          kidx_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [ACC_WIDTH-1:0]       acc_q, result_q;
  logic                       busy_q, sram_en_q, valid_q, done_q;

  logic [2*DATA_WIDTH-1:0]    prod_d;
  logic [ACC_WIDTH-1:0]       sum_d;
  logic [KC_W-1:0]            kr_d, kc_d;
  logic [RC_W-1:0]            row_d, col_d;
  logic                       last_tap_d, last_win_d;

  function automatic logic [SRAM_ADDR_WIDTH-1:0] pix_addr(
    input logic [RC_W-1:0] r, input logic [RC_W-1:0] c,
    input logic [KC_W-1:0] dr, input logic [KC_W-1:0] dc);
    int unsigned a;
    a = (32'(r) + 32'(dr)) * 32'(IMG_WIDTH) + 32'(c) + 32'(dc);
    return a[SRAM_ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] clamp_result(input logic [ACC_WIDTH-1:0] sum);
`ifdef CONV_WINDOW_SAT_EN
    logic [ACC_WIDTH-1:0] lim;
    lim = ACC_WIDTH'({DATA_WIDTH{1'b1}});
    return (sum > lim) ? lim : sum;
`else
    return sum;
`endif
  endfunction

  always_comb begin
    prod_d     = {{DATA_WIDTH{1'b0}}, i_sram_data} * {{DATA_WIDTH{1'b0}}, i_kernel_data};
    sum_d      = acc_q + ACC_WIDTH'(prod_d);
    last_tap_d = (kr_q == K_LAST) && (kc_q == K_LAST);
    last_win_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    kc_d       = (kc_q == K_LAST) ? '0 : kc_q + KC_W'(1);
    kr_d       = (kc_q == K_LAST) ? kr_q + KC_W'(1) : kr_q;
    col_d      = (col_q == COL_LAST) ? '0 : col_q + RC_W'(1);
    row_d      = (col_q == COL_LAST) ? row_q + RC_W'(1) : row_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      kidx_q    <= '0;
      addr_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      sram_en_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          state_q   <= S_FETCH;
          row_q     <= '0;
          col_q     <= '0;
          kr_q      <= '0;
          kc_q      <= '0;
          kidx_q    <= '0;
          addr_q    <= '0;
          acc_q     <= '0;
          busy_q    <= 1'b1;
          sram_en_q <= 1'b1;
        end
        S_FETCH: begin
          // Read data lags its address by one cycle, so the first tap has nothing to add yet.
          if (kidx_q != '0) acc_q <= sum_d;
          if (last_tap_d) begin
            state_q   <= S_DRAIN;
            sram_en_q <= 1'b0;
          end else begin
            kr_q   <= kr_d;
            kc_q   <= kc_d;
            kidx_q <= kidx_q + KIDX_W'(1);
            addr_q <= pix_addr(row_q, col_q, kr_d, kc_d);
          end
        end
        S_DRAIN: begin
          acc_q    <= sum_d;
          result_q <= clamp_result(sum_d);
          valid_q  <= 1'b1;
          state_q  <= S_OUTPUT;
        end
        S_OUTPUT: if (i_result_ready) begin
          valid_q <= 1'b0;
          if (last_win_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            kr_q      <= '0;
            kc_q      <= '0;
            kidx_q    <= '0;
            acc_q     <= '0;
            addr_q    <= pix_addr(row_d, col_d, '0, '0);
            sram_en_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_sram_en      = sram_en_q;
  assign o_sram_addr    = addr_q;
  assign o_kernel_idx   = kidx_q;
  assign o_result       = result_q;
  assign o_result_valid = valid_q;
  assign o_done         = done_q;

endmodule
